// File: rtl/mc_bus_pkg.sv
// Shared definitions for the MCU memory-controller write-capture path:
// bus width defaults, capture FSM encoding and the queued entry layout.
package mc_bus_pkg;

  localparam int DEF_MC_DATA_WIDTH = 16;
  localparam int DEF_MC_ADD_WIDTH  = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } cap_state_t;

  // Entry layout is {add, data}; address sits in the upper bits.
  typedef struct packed {
    logic [DEF_MC_ADD_WIDTH-1:0]  add;
    logic [DEF_MC_DATA_WIDTH-1:0] data;
  } mc_entry_t;

  localparam int DEF_ENTRY_WIDTH = $bits(mc_entry_t);

  function automatic int entry_width(input int add_width, input int data_width);
    return add_width + data_width;
  endfunction

endpackage

// File: rtl/mc_sync_fifo.sv
// Generic single-clock show-ahead FIFO; the head entry is visible on pop_data
// whenever empty is low, and a push into a full FIFO is accepted only with a pop.
module mc_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mc_write_capture.sv
// Captures asynchronous MCU write cycles into the clock domain and queues
// each completed write as an {address, data} entry behind a valid/ready port.
module mc_write_capture
  import mc_bus_pkg::*;
#(
  parameter int MC_DATA_WIDTH = DEF_MC_DATA_WIDTH,
  parameter int MC_ADD_WIDTH  = DEF_MC_ADD_WIDTH,
  parameter int FIFO_DEPTH    = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mc_ce,
  input  logic                         mc_we,
  input  logic                         mc_oe,
  input  logic [MC_ADD_WIDTH-1:0]      mc_add,
  input  logic [MC_DATA_WIDTH-1:0]     mc_din,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [MC_ADD_WIDTH-1:0]      wr_add,
  output logic [MC_DATA_WIDTH-1:0]     wr_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  output logic                         protocol_err,
  input  logic                         err_clr
);

  localparam int EW = entry_width(MC_ADD_WIDTH, MC_DATA_WIDTH);

  logic [SYNC_STAGES-1:0]   ce_sync;
  logic [SYNC_STAGES-1:0]   we_sync;
  logic [SYNC_STAGES-1:0]   oe_sync;
  logic                     ce_s;
  logic                     we_s;
  logic                     oe_s;
  logic [MC_ADD_WIDTH-1:0]  add_pipe  [SYNC_STAGES];
  logic [MC_DATA_WIDTH-1:0] data_pipe [SYNC_STAGES];

  cap_state_t               state;
  cap_state_t               state_next;
  logic                     bad;
  logic                     bad_next;
  logic                     hold_load;
  logic                     push;
  logic                     proto_set;
  logic                     overflow_set;
  logic [MC_ADD_WIDTH-1:0]  hold_add;
  logic [MC_DATA_WIDTH-1:0] hold_data;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic [EW-1:0]            head;

  // Strobe synchronizers idle high so a cycle already in progress at reset
  // release is still seen as a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ce_sync <= '1;
      we_sync <= '1;
      oe_sync <= '1;
    end else begin
      ce_sync <= {ce_sync[SYNC_STAGES-2:0], mc_ce};
      we_sync <= {we_sync[SYNC_STAGES-2:0], mc_we};
      oe_sync <= {oe_sync[SYNC_STAGES-2:0], mc_oe};
    end
  end

  assign ce_s = ce_sync[SYNC_STAGES-1];
  assign we_s = we_sync[SYNC_STAGES-1];
  assign oe_s = oe_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        add_pipe[i]  <= '0;
        data_pipe[i] <= '0;
      end
    end else begin
      add_pipe[0]  <= mc_add;
      data_pipe[0] <= mc_din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        add_pipe[i]  <= add_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bad       <= 1'b0;
      hold_add  <= '0;
      hold_data <= '0;
    end else begin
      state <= state_next;
      bad   <= bad_next;
      if (hold_load) begin
        hold_add  <= add_pipe[SYNC_STAGES-1];
        hold_data <= data_pipe[SYNC_STAGES-1];
      end
    end
  end

  // The last sample taken with both strobes low is the one that gets queued.
  always_comb begin
    state_next = state;
    bad_next   = bad;
    hold_load  = 1'b0;
    push       = 1'b0;
    proto_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!ce_s && !we_s) begin
          state_next = ACTIVE;
          hold_load  = 1'b1;
          bad_next   = !oe_s;
        end
      end
      ACTIVE: begin
        if (!ce_s && !we_s) begin
          hold_load = 1'b1;
          bad_next  = bad | !oe_s;
        end else begin
          state_next = IDLE;
          if (bad) proto_set = 1'b1;
          else     push      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop          = wr_valid && wr_ready;
  assign overflow_set = push && fifo_full && !pop;

  // A set event on the same cycle as err_clr takes priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (overflow_set) overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (proto_set)    protocol_err <= 1'b1;
      else if (err_clr) protocol_err <= 1'b0;
    end
  end

  mc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({hold_add, hold_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign wr_valid = !fifo_empty;
  assign wr_add   = head[EW-1:MC_DATA_WIDTH];
  assign wr_data  = head[MC_DATA_WIDTH-1:0];

endmodule
